// File: rtl/keypad_emulator_if.sv
// Command handshake between a key-press sequencer and keypad_emulator.
// Each beat carries the key code to press and how many cycles to hold it closed.
interface keypad_emulator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder: queued key presses close one contact which answers the column scan on the rows.
// Optional contact bounce on press/release is compiled in with the KEYPAD_EMU_BOUNCE_EN macro.
module keypad_emulator #(
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_CYCLES = 2000,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         col,
  output logic [3:0]         row,
  keypad_emulator_if.slave   cmd,
  output logic               busy,
  output logic               done,
  output logic               key_down
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_emulator: FIFO_DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65536) begin : g_bad_gap
    $error("keypad_emulator: GAP_CYCLES must be in 1..65536");
  end
  if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 65536) begin : g_bad_bounce
    $error("keypad_emulator: BOUNCE_CYCLES must be in 1..65536");
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  typedef enum logic [2:0] {
    IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP
  } state_t;
  localparam state_t      PRESS_ENTRY = BOUNCE_IN;
  localparam state_t      AFTER_HOLD  = BOUNCE_OUT;
  localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);
`else
  typedef enum logic [2:0] {
    IDLE, HOLD, GAP
  } state_t;
  localparam state_t      PRESS_ENTRY = HOLD;
  localparam state_t      AFTER_HOLD  = GAP;
`endif

  // Command queue storing {key, hold}
  logic [19:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [19:0]   head;

  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign push          = cmd.cmd_valid && !full;
  assign cmd.cmd_ready = !full;
  assign head          = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd.cmd_key, cmd.cmd_hold};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Physical position {row, col} of each key code on the board's keypad
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    case (key)
      4'd0:    key_pos = {2'd3, 2'd1};
      4'd1:    key_pos = {2'd0, 2'd0};
      4'd2:    key_pos = {2'd0, 2'd1};
      4'd3:    key_pos = {2'd0, 2'd2};
      4'd4:    key_pos = {2'd1, 2'd0};
      4'd5:    key_pos = {2'd1, 2'd1};
      4'd6:    key_pos = {2'd1, 2'd2};
      4'd7:    key_pos = {2'd2, 2'd0};
      4'd8:    key_pos = {2'd2, 2'd1};
      4'd9:    key_pos = {2'd2, 2'd2};
      4'd10:   key_pos = {2'd0, 2'd3};
      4'd11:   key_pos = {2'd1, 2'd3};
      4'd12:   key_pos = {2'd2, 2'd3};
      4'd13:   key_pos = {2'd3, 2'd3};
      4'd14:   key_pos = {2'd3, 2'd0};
      4'd15:   key_pos = {2'd3, 2'd2};
      default: key_pos = 4'd0;
    endcase
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] hold_last;
  logic [1:0]  row_sel;
  logic [1:0]  col_sel;
  logic        contact_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = PRESS_ENTRY;
          cnt_d   = '0;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_IN: begin
        if (cnt_q == BOUNCE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      HOLD: begin
        if (cnt_q == hold_last) begin
          state_d = AFTER_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_OUT: begin
        if (cnt_q == BOUNCE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          done  = 1'b1;
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = PRESS_ENTRY;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Contact level for the coming cycle; bounce toggles every 4 counts (bit 2 of the counter)
  always_comb begin
    contact_d = 1'b0;
    case (state_d)
      HOLD:       contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_IN:  contact_d = ~cnt_d[2];
      BOUNCE_OUT: contact_d = cnt_d[2];
`endif
      default:    contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_down  <= 1'b0;
      row_sel   <= '0;
      col_sel   <= '0;
      hold_last <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_down <= contact_d;
      if (pop) begin
        {row_sel, col_sel} <= key_pos(head[19:16]);
        hold_last          <= (head[15:0] == 16'd0) ? 16'd0 : head[15:0] - 16'd1;
      end
    end
  end

  // Rows answer the column drive combinationally, like a real switch matrix
  always_comb begin
    row = 4'b0000;
    if (key_down && col[col_sel]) begin
      row[row_sel] = 1'b1;
    end
  end

  assign busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: each accepted command queues its expected press signature,
// and a monitor pops and compares it whenever done pulses.
module tb_keypad_emulator;

  localparam int FIFO_DEPTH    = 4;
  localparam int BOUNCE_CYCLES = 16;
  localparam int GAP_CYCLES    = 8;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BOUNCE_LEN = 16;
`else
  localparam int BOUNCE_LEN = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       done;
  logic       key_down;

  keypad_emulator_if ifc ();

  keypad_emulator #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .cmd      (ifc),
    .busy     (busy),
    .done     (done),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] row_acc;
    int         hi;
  } exp_t;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   bad_checks   = 0;
  int   done_seen    = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One command; the expected press signature is queued on the accepting edge
  task automatic applyStimulus(input logic [3:0] key, input logic [15:0] hold, input logic [3:0] exp_row);
    exp_t e;
    bit   ok;
    ok            = 1'b0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_key   = key;
    ifc.cmd_hold  = hold;
    for (int i = 0; i < 400; i++) begin
      if (ifc.cmd_ready) begin
        @(posedge clk);
        e.row_acc = exp_row;
        e.hi      = ((hold == 16'd0) ? 1 : int'(hold)) + BOUNCE_LEN;
        exp_q.push_back(e);
        ok = 1'b1;
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    ifc.cmd_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic waitIdle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  // Monitor: accumulate contact cycles and row response, compare on each done pulse
  initial begin : monitor
    int         hi_cnt;
    logic [3:0] racc;
    exp_t       e;
    hi_cnt = 0;
    racc   = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hi_cnt = 0;
        racc   = 4'b0000;
      end else begin
        if (key_down) begin
          hi_cnt++;
          racc = racc | row;
        end
        if (done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("press_cycles", 32'(hi_cnt), 32'(e.hi));
            checkOutput("press_row", 32'(racc), 32'(e.row_acc));
          end
          hi_cnt = 0;
          racc   = 4'b0000;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0]  walk_col [5];
    logic [3:0]  walk_row [5];
    logic [39:0] pat;
    int          dk;
    int          done_base;
    int          kd_seen;
    int          done_after;

    walk_col = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
    walk_row = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};

    rst           = 1'b1;
    col           = 4'b0000;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_key   = 4'd0;
    ifc.cmd_hold  = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_row", 32'(row), 32'd0);
    checkOutput("reset_key_down", 32'(key_down), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(ifc.cmd_ready), 32'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] clean press key 5 hold 10");
    col = 4'b0010;
    applyStimulus(4'd5, 16'd10, 4'b0010);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("kd_before_pop", 32'(key_down), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("kd_after_pop", 32'(key_down), 32'd1);
    checkOutput("row_after_pop", 32'(row), 32'b0010);
    dk = 0;
    for (int k = 2; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dk = k;
        break;
      end
    end
    checkOutput("done_latency", 32'(dk), 32'(18 + 2 * BOUNCE_LEN));
    @(posedge clk);
    #1;
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("done_one_cycle", 32'(done), 32'd0);

    $display("[TB] column scan key 15, then queue fill");
    col       = 4'b1111;
    done_base = done_seen;
    applyStimulus(4'd15, 16'd40, 4'b1000);
    repeat (2 + BOUNCE_LEN) @(posedge clk);
    #1;
    checkOutput("kd_in_hold", 32'(key_down), 32'd1);
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      col = walk_col[i];
      #1;
      checkOutput("scan_row", 32'(row), 32'(walk_row[i]));
    end
    col = 4'b1111;
    @(posedge clk);
    #1;
    applyStimulus(4'd1, 16'd3, 4'b0001);
    applyStimulus(4'd2, 16'd3, 4'b0001);
    applyStimulus(4'd3, 16'd3, 4'b0001);
    applyStimulus(4'd10, 16'd3, 4'b0001);
    checkOutput("ready_when_full", 32'(ifc.cmd_ready), 32'd0);
    checkOutput("busy_when_full", 32'(busy), 32'd1);
    applyStimulus(4'd4, 16'd2, 4'b0010);
    waitIdle("idle_after_queue", 1500);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("done_count_queue", 32'(done_seen - done_base), 32'd6);

    $display("[TB] zero hold key 0");
    col = 4'b0010;
    applyStimulus(4'd0, 16'd0, 4'b1000);
    waitIdle("idle_after_hold0", 200);

`ifdef KEYPAD_EMU_BOUNCE_EN
    $display("[TB] bounce pattern key 8 hold 4");
    pat = 40'b1111000011110000_1111_0000111100001111_0000;
    applyStimulus(4'd8, 16'd4, 4'b0100);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bounce_kd", 32'(key_down), 32'(pat[39-k]));
    end
    waitIdle("idle_after_bounce", 200);
`endif

    $display("[TB] reset during hold with two queued");
    col = 4'b1111;
    applyStimulus(4'd9, 16'd50, 4'b0100);
    repeat (3 + BOUNCE_LEN) @(posedge clk);
    #1;
    applyStimulus(4'd2, 16'd5, 4'b0001);
    applyStimulus(4'd3, 16'd5, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("kd_before_reset", 32'(key_down), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("row_async_reset", 32'(row), 32'd0);
    checkOutput("kd_async_reset", 32'(key_down), 32'd0);
    checkOutput("busy_async_reset", 32'(busy), 32'd0);
    checkOutput("ready_async_reset", 32'(ifc.cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    kd_seen    = 0;
    done_after = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (key_down) kd_seen++;
      if (done) done_after++;
    end
    checkOutput("no_press_after_reset", 32'(kd_seen), 32'd0);
    checkOutput("no_done_after_reset", 32'(done_after), 32'd0);
    checkOutput("busy_after_reset", 32'(busy), 32'd0);
    checkOutput("ready_after_reset", 32'(ifc.cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
